onehot_decoder_q: RTL

//  Parametrised, registered binary-to-one-hot decoder with valid/ready handshaking on both sides.

---
 rtl/onehot_dec_pkg.sv | 22 ++
 rtl/dec_fifo2.sv | 56 +++++
 rtl/onehot_decoder_q.sv | 82 ++++++++
 3 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared constants and decode helper for the registered one-hot decoder.
// The helper works at the widest supported size; callers slice what they need.
package onehot_dec_pkg;

  localparam int MODE_REPLACE = 0;
  localparam int MODE_ACCUM   = 1;
  localparam int MAX_N        = 256;

  // Returns {bitmap[MAX_N-1:0], err}
  function automatic logic [MAX_N:0] decode(
    input logic [7:0] idx,
    input int         out_n
  );
    logic [MAX_N-1:0] bm;
    logic             err;
    err = (32'(idx) >= out_n);
    bm  = '0;
    if (!err) bm[idx] = 1'b1;
    return {bm, err};
  endfunction

endpackage

// File: rtl/dec_fifo2.sv
// Two-entry register FIFO holding decoded entries.
// Output reads as zero whenever the FIFO is empty.
module dec_fifo2
  import onehot_dec_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != 2'd2);
    pop_ok   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop_ok) rd_d = ~rd_q;
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
    end
  end

  assign dout  = (count_q != 2'd0) ? mem_q[rd_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/onehot_decoder_q.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides,
// optional sticky OR-accumulate and a two-entry output queue.
module onehot_decoder_q
  import onehot_dec_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_N = 8,
  parameter int MODE  = MODE_REPLACE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_idx,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] out_onehot,
  output logic             out_err
);

  localparam int W = OUT_N + 1;

  logic [MAX_N:0]   dec_full;
  logic [OUT_N-1:0] dec;
  logic             err;
  logic             accept;
  logic             pop;
  logic [W-1:0]     entry;
  logic [W-1:0]     dout;
  logic [1:0]       count;
  logic             unused_dec;

  always_comb begin
    dec_full = decode(8'(in_idx), OUT_N);
    dec      = dec_full[OUT_N:1];
    err      = dec_full[0];
  end

  assign unused_dec = ^dec_full;

  // Ready depends only on registered occupancy, never on out_ready
  assign in_ready  = !reset && (count != 2'd2);
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  if (MODE == MODE_ACCUM) begin : g_acc
    logic [OUT_N-1:0] acc_q, acc_d;

    always_comb begin
      acc_d = (clr ? '0 : acc_q) | (accept ? dec : '0);
    end

    always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
    end

    assign entry = {acc_d, err};
  end else begin : g_rep
    logic unused_clr;
    assign unused_clr = clr;
    assign entry      = {dec, err};
  end

  dec_fifo2 #(
    .WIDTH (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .din   (entry),
    .dout  (dout),
    .count (count)
  );

  assign out_onehot = dout[W-1:1];
  assign out_err    = dout[0];

endmodule
